alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
- Upstream issue stage for the 16-bit registered ALU (`myalu`).
- Holds a small operand register file and accepts one three-register instruction at a time over a valid/ready handshake.
- Drives the ALU operands and opcode, then writes the ALU result back into the register file.
- Latches carry, overflow and zero into a status register and signals completion with a one-cycle done pulse.

Parameters:
- NUMBITS, 16, datapath width; must match the ALU's NUMBITS.
- ADDRW, 3, register-address width; the register file has 2**ADDRW entries.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted); release is synchronous to clk at the integration level.
- ld_en  input  1  host register-load strobe.
- ld_addr  input  ADDRW  host load address.
- ld_data  input  NUMBITS  host load data.
- in_valid  input  1  instruction valid.
- in_ready  output  1  instruction accepted when in_valid & in_ready.
- in_op  input  3  ALU opcode, passed through unchanged.
- in_rs1  input  ADDRW  source A register.
- in_rs2  input  ADDRW  source B register.
- in_rd  input  ADDRW  destination register.
- alu_a  output  NUMBITS  registered ALU operand A.
- alu_b  output  NUMBITS  registered ALU operand B.
- alu_opcode  output  3  registered ALU opcode.
- alu_result  input  NUMBITS  ALU result.
- alu_carryout  input  1  ALU carry flag.
- alu_overflow  input  1  ALU overflow flag.
- alu_zero  input  1  ALU zero flag.
- done  output  1  one-cycle pulse; writeback completed.
- wb_data  output  NUMBITS  value written back; held until next writeback.
- flag_c  output  1  status carry.
- flag_v  output  1  status overflow.
- flag_z  output  1  status zero.
- dbg_addr  input  ADDRW  debug read address.
- dbg_data  output  NUMBITS  combinational read of rf[dbg_addr].

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - All register-file entries, alu_a, alu_b, alu_opcode, wb_data, done and all flags go to 0.
- Register 0 always reads 0; writes to it (load or writeback) are discarded.
- FSM states: IDLE, EXEC, WB.
- in_ready = (state==IDLE) & !ld_en. Loads take priority over issue in the same cycle.
- IDLE:
  - If ld_en: rf[ld_addr] <= ld_data.
  - Else if in_valid: latch in_rd; alu_a <= rf[in_rs1]; alu_b <= rf[in_rs2]; alu_opcode <= in_op; go to EXEC.
  - Operands are read from the register file as it stands before this edge.
- EXEC:
  - The ALU captures alu_a, alu_b and alu_opcode on this edge.
  - Go to WB. ld_en and in_valid are ignored.
- WB:
  - ALU outputs are stable.
  - On the edge: rf[rd] <= alu_result (unless rd==0); wb_data <= alu_result; flag_c/v/z <= alu_carryout/alu_overflow/alu_zero; done <= 1; go to IDLE.
  - Flags update even when rd==0.
- done is high for exactly one cycle, the first IDLE cycle after WB.
- Latency: accept edge N; writeback edge N+2; done high during cycle N+2..N+3.
- Throughput: one instruction per 3 cycles. The next accept is possible at edge N+3.
- rs1, rs2 and rd may alias freely. A following instruction reading rd sees the new value; no forwarding is needed.
- alu_a, alu_b and alu_opcode hold their last values outside EXEC.
- Reset mid-operation (EXEC or WB): the instruction is dropped, there is no writeback and no done pulse, and the register file clears.
- The ALU result is taken as NUMBITS bits; no width extension. Flags are copied verbatim from the ALU; this block does no flag computation.

Optional Feature:
- Macro: ALU_ISSUE_IMM_EN.
- Defined:
  - Adds ports in_use_imm (input, 1) and in_imm (input, NUMBITS).
  - On accept with in_use_imm=1: alu_b <= in_imm instead of rf[in_rs2]; in_rs2 is ignored.
- Undefined:
  - Ports absent.
  - alu_b is always sourced from rf[in_rs2].

Test Plan:
- Reset and load:
  - Assert reset=0 mid-run: all outputs 0 immediately.
  - Release, ld r1=0x1234: dbg_addr=1 reads 0x1234; ld r0=0xFFFF: dbg_data at addr 0 reads 0x0000.
- Unsigned add with carry:
  - r1=0xFFFF, r2=0x0001, op=000, rd=3.
  - Expect done 2 cycles after accept, r3=0x0000, wb_data=0x0000, flag_c=1, flag_z=1, flag_v=0.
- Logic op and aliasing:
  - r4=0x00F0, op=110 (XOR), rs1=rs2=rd=4.
  - Expect r4=0x0000, flag_z=1. Follow with op=101 (OR) using r1=0x1234, r4: result 0x1234.
- Handshake:
  - in_valid held high with two queued instructions.
  - Expect in_ready low for the 2 cycles after the first accept, second accept exactly 3 cycles after the first, one done pulse per instruction.
  - ld_en=1 together with in_valid in IDLE: load performed, instruction not accepted that cycle.
- Reset mid-EXEC:
  - Issue op=000 into rd=5, then drive reset=0 during EXEC.
  - Expect no done, r5=0, state IDLE, in_ready=1 after release.
- ALU_ISSUE_IMM_EN:
  - r1=0x0010, in_use_imm=1, in_imm=0x0005, op=000, rd=2.
  - Expect r2=0x0015, flag_c=0, flag_z=0.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue stage for the registered 16-bit ALU (myalu).
// Holds a small operand register file, issues one three-register instruction per
// valid/ready handshake, writes the ALU result back and latches the status flags.
// Optional immediate B operand: define ALU_ISSUE_IMM_EN to add in_use_imm/in_imm.
module alu_issue_ctrl #(
   parameter int unsigned NUMBITS = 16,
   parameter int unsigned ADDRW   = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               ld_en,
   input  logic [ADDRW-1:0]   ld_addr,
   input  logic [NUMBITS-1:0] ld_data,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [2:0]         in_op,
   input  logic [ADDRW-1:0]   in_rs1,
   input  logic [ADDRW-1:0]   in_rs2,
   input  logic [ADDRW-1:0]   in_rd,
`ifdef ALU_ISSUE_IMM_EN
   input  logic               in_use_imm,
   input  logic [NUMBITS-1:0] in_imm,
`endif
   output logic [NUMBITS-1:0] alu_a,
   output logic [NUMBITS-1:0] alu_b,
   output logic [2:0]         alu_opcode,
   input  logic [NUMBITS-1:0] alu_result,
   input  logic               alu_carryout,
   input  logic               alu_overflow,
   input  logic               alu_zero,
   output logic               done,
   output logic [NUMBITS-1:0] wb_data,
   output logic               flag_c,
   output logic               flag_v,
   output logic               flag_z,
   input  logic [ADDRW-1:0]   dbg_addr,
   output logic [NUMBITS-1:0] dbg_data
);

   localparam int unsigned NumRegs = 2 ** ADDRW;

   typedef enum logic [1:0] {StIdle, StExec, StWb} state_e;

   state_e             state_q, state_d;
   logic [NUMBITS-1:0] rf_q [NumRegs];
   logic [ADDRW-1:0]   rd_q;
   logic [NUMBITS-1:0] alu_a_q, alu_b_q, wb_data_q;
   logic [2:0]         alu_opcode_q;
   logic               done_q, flag_c_q, flag_v_q, flag_z_q;
   logic [NUMBITS-1:0] opnd_b;
   logic               accept;

   // FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= StIdle;
      else        state_q <= state_d;
   end

   // FSM next state: a load in IDLE blocks issue for that cycle
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (!ld_en && in_valid) state_d = StExec;
         StExec:  state_d = StWb;
         StWb:    state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // FSM outputs: handshake
   always_comb begin
      in_ready = (state_q == StIdle) && !ld_en;
      accept   = in_ready && in_valid;
   end

   // B operand source select
   always_comb begin
      opnd_b = rf_q[in_rs2];
`ifdef ALU_ISSUE_IMM_EN
      if (in_use_imm) opnd_b = in_imm;
`endif
   end

   // Operand/opcode capture on accept, result and flag capture in WB
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_q         <= '0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_opcode_q <= '0;
         wb_data_q    <= '0;
         done_q       <= 1'b0;
         flag_c_q     <= 1'b0;
         flag_v_q     <= 1'b0;
         flag_z_q     <= 1'b0;
      end else begin
         done_q <= (state_q == StWb);
         if (accept) begin
            rd_q         <= in_rd;
            alu_a_q      <= rf_q[in_rs1];
            alu_b_q      <= opnd_b;
            alu_opcode_q <= in_op;
         end
         // Flags update even when the destination is r0
         if (state_q == StWb) begin
            wb_data_q <= alu_result;
            flag_c_q  <= alu_carryout;
            flag_v_q  <= alu_overflow;
            flag_z_q  <= alu_zero;
         end
      end
   end

   // Register file; entry 0 is never written so it always reads 0
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < NumRegs; i++) rf_q[i] <= '0;
      end else begin
         if (state_q == StIdle && ld_en && ld_addr != '0) begin
            rf_q[ld_addr] <= ld_data;
         end else if (state_q == StWb && rd_q != '0) begin
            rf_q[rd_q] <= alu_result;
         end
      end
   end

   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_opcode = alu_opcode_q;
   assign done       = done_q;
   assign wb_data    = wb_data_q;
   assign flag_c     = flag_c_q;
   assign flag_v     = flag_v_q;
   assign flag_z     = flag_z_q;
   assign dbg_data   = rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a behavioural registered ALU.
module tb_alu_issue_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        ld_en = 1'b0;
   logic [2:0]  ld_addr = '0;
   logic [15:0] ld_data = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  in_op = '0;
   logic [2:0]  in_rs1 = '0;
   logic [2:0]  in_rs2 = '0;
   logic [2:0]  in_rd = '0;
`ifdef ALU_ISSUE_IMM_EN
   logic        in_use_imm = 1'b0;
   logic [15:0] in_imm = '0;
`endif
   logic [15:0] alu_a, alu_b;
   logic [2:0]  alu_opcode;
   logic [15:0] alu_result = '0;
   logic        alu_carryout = 1'b0;
   logic        alu_overflow = 1'b0;
   logic        alu_zero = 1'b0;
   logic        done;
   logic [15:0] wb_data;
   logic        flag_c, flag_v, flag_z;
   logic [2:0]  dbg_addr = '0;
   logic [15:0] dbg_data;

   int n_checks = 0;
   int n_fail = 0;
   logic [15:0] m_rf [8];

   always #5 clk = ~clk;

   alu_issue_ctrl #(.NUMBITS(16), .ADDRW(3)) dut (
      .clk(clk), .reset(reset), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rs1(in_rs1),
      .in_rs2(in_rs2), .in_rd(in_rd),
`ifdef ALU_ISSUE_IMM_EN
      .in_use_imm(in_use_imm), .in_imm(in_imm),
`endif
      .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_result(alu_result),
      .alu_carryout(alu_carryout), .alu_overflow(alu_overflow), .alu_zero(alu_zero),
      .done(done), .wb_data(wb_data), .flag_c(flag_c), .flag_v(flag_v), .flag_z(flag_z),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   // Behavioural ALU: returns {carry, overflow, zero, result}
   function automatic logic [18:0] alu_fn(input logic [2:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
      logic [16:0] s;
      logic [15:0] r;
      logic        c, v;
      s = '0; r = '0; c = 1'b0; v = 1'b0;
      case (op)
         3'd0: begin
            s = {1'b0, a} + {1'b0, b}; r = s[15:0]; c = s[16];
            v = (a[15] == b[15]) && (r[15] != a[15]);
         end
         3'd1: begin
            s = {1'b0, a} - {1'b0, b}; r = s[15:0]; c = s[16];
            v = (a[15] != b[15]) && (r[15] != a[15]);
         end
         3'd2: r = a << b[3:0];
         3'd3: r = a >> b[3:0];
         3'd4: r = a & b;
         3'd5: r = a | b;
         3'd6: r = a ^ b;
         default: r = ~a;
      endcase
      return {c, v, (r == 16'h0), r};
   endfunction

   // Registered ALU: captures operands every edge, result valid the next cycle
   always_ff @(posedge clk) begin
      {alu_carryout, alu_overflow, alu_zero, alu_result} <= alu_fn(alu_opcode, alu_a, alu_b);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_model();
      for (int i = 0; i < 8; i++) m_rf[i] = 16'h0;
   endtask

   task automatic load(input logic [2:0] a, input logic [15:0] d);
      ld_en = 1'b1; ld_addr = a; ld_data = d;
      tick();
      ld_en = 1'b0;
      if (a != 3'd0) m_rf[a] = d;
   endtask

   // Issue one instruction alone and check every stage against the model
   task automatic run_instr(input logic [2:0] op, input logic [2:0] rs1, input logic [2:0] rs2,
                            input logic [2:0] rd, input logic use_imm, input logic [15:0] imm,
                            input string tag);
      logic [15:0] a, b;
      logic [18:0] e;
      a = m_rf[rs1];
      b = m_rf[rs2];
`ifdef ALU_ISSUE_IMM_EN
      if (use_imm) b = imm;
      in_use_imm = use_imm; in_imm = imm;
`else
      if (use_imm && imm != imm) b = imm;
`endif
      e = alu_fn(op, a, b);
      in_valid = 1'b1; in_op = op; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL %s ready_idle: got %b want 1", tag, in_ready);
      end
      tick();
      in_valid = 1'b0;
      in_op = 3'($urandom); in_rs1 = 3'($urandom); in_rs2 = 3'($urandom);
      in_rd = 3'($urandom);
      n_checks++;
      if ({alu_a, alu_b, alu_opcode} !== {a, b, op}) begin
         n_fail++;
         $display("FAIL %s operands: got %h/%h/%0d want %h/%h/%0d", tag, alu_a, alu_b,
                  alu_opcode, a, b, op);
      end
      n_checks++;
      if ({in_ready, done} !== 2'b00) begin
         n_fail++; $display("FAIL %s exec_ready_done: got %b want 00", tag, {in_ready, done});
      end
      tick();
      n_checks++;
      if ({in_ready, done} !== 2'b00) begin
         n_fail++; $display("FAIL %s wb_ready_done: got %b want 00", tag, {in_ready, done});
      end
      tick();
      if (rd != 3'd0) m_rf[rd] = e[15:0];
      dbg_addr = rd;
      #1;
      n_checks++;
      if ({done, in_ready, flag_c, flag_v, flag_z, wb_data} !== {2'b11, e}) begin
         n_fail++;
         $display("FAIL %s writeback: got done=%b rdy=%b cvz=%b%b%b wb=%h want 11 %b %h", tag,
                  done, in_ready, flag_c, flag_v, flag_z, wb_data, e[18:16], e[15:0]);
      end
      n_checks++;
      if (dbg_data !== m_rf[rd]) begin
         n_fail++; $display("FAIL %s rf_rd: got %h want %h", tag, dbg_data, m_rf[rd]);
      end
      tick();
      n_checks++;
      if (done !== 1'b0) begin
         n_fail++; $display("FAIL %s done_width: got %b want 0", tag, done);
      end
   endtask

   task automatic test_load();
      load(3'd1, 16'h1234);
      dbg_addr = 3'd1; #1;
      n_checks++;
      if (dbg_data !== 16'h1234) begin
         n_fail++; $display("FAIL load_r1: got %h want 1234", dbg_data);
      end
      load(3'd0, 16'hFFFF);
      dbg_addr = 3'd0; #1;
      n_checks++;
      if (dbg_data !== 16'h0000) begin
         n_fail++; $display("FAIL load_r0: got %h want 0000", dbg_data);
      end
   endtask

   task automatic test_add_carry();
      load(3'd1, 16'hFFFF);
      load(3'd2, 16'h0001);
      run_instr(3'd0, 3'd1, 3'd2, 3'd3, 1'b0, 16'h0, "add_carry");
      dbg_addr = 3'd3; #1;
      n_checks++;
      if ({dbg_data, wb_data, flag_c, flag_z, flag_v} !== {16'h0, 16'h0, 3'b110}) begin
         n_fail++;
         $display("FAIL add_carry_const: got r3=%h wb=%h czv=%b%b%b want 0000 0000 110",
                  dbg_data, wb_data, flag_c, flag_z, flag_v);
      end
   endtask

   task automatic test_logic_alias();
      load(3'd4, 16'h00F0);
      run_instr(3'd6, 3'd4, 3'd4, 3'd4, 1'b0, 16'h0, "xor_alias");
      dbg_addr = 3'd4; #1;
      n_checks++;
      if ({dbg_data, flag_z} !== {16'h0, 1'b1}) begin
         n_fail++; $display("FAIL xor_alias_const: got r4=%h z=%b want 0000 1", dbg_data, flag_z);
      end
      load(3'd1, 16'h1234);
      run_instr(3'd5, 3'd1, 3'd4, 3'd5, 1'b0, 16'h0, "or_follow");
      n_checks++;
      if (wb_data !== 16'h1234) begin
         n_fail++; $display("FAIL or_follow_const: got %h want 1234", wb_data);
      end
   endtask

   task automatic test_reset();
      run_instr(3'd1, 3'd0, 3'd1, 3'd6, 1'b0, 16'h0, "pre_reset_sub");
      #2 reset = 1'b0;
      #1;
      n_checks++;
      if ({alu_a, alu_b, alu_opcode, wb_data, done, flag_c, flag_v, flag_z} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got a=%h b=%h op=%0d wb=%h d=%b cvz=%b%b%b want 0",
                  alu_a, alu_b, alu_opcode, wb_data, done, flag_c, flag_v, flag_z);
      end
      for (int i = 0; i < 8; i++) begin
         dbg_addr = 3'(i); #1;
         n_checks++;
         if (dbg_data !== 16'h0) begin
            n_fail++; $display("FAIL reset_rf%0d: got %h want 0000", i, dbg_data);
         end
      end
      tick();
      reset = 1'b1;
      clear_model();
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_ready: got %b want 1", in_ready);
      end
   endtask

   task automatic test_handshake();
      logic [18:0] ea, eb;
      logic [15:0] d6;
      load(3'd1, 16'h0003);
      load(3'd2, 16'h0005);
      ea = alu_fn(3'd0, m_rf[1], m_rf[2]);
      in_valid = 1'b1; in_op = 3'd0; in_rs1 = 3'd1; in_rs2 = 3'd2; in_rd = 3'd3;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL hs_first_ready: got %b want 1", in_ready);
      end
      tick();
      m_rf[3] = ea[15:0];
      eb = alu_fn(3'd0, m_rf[3], m_rf[1]);
      in_op = 3'd0; in_rs1 = 3'd3; in_rs2 = 3'd1; in_rd = 3'd4;
      for (int c = 1; c <= 7; c++) begin
         n_checks++;
         case (c)
            1, 2, 4, 5: if ({in_ready, done} !== 2'b00) begin
               n_fail++; $display("FAIL hs_busy_c%0d: got %b want 00", c, {in_ready, done});
            end
            3: if ({in_ready, done, wb_data} !== {2'b11, ea[15:0]}) begin
               n_fail++;
               $display("FAIL hs_first_done: got r=%b d=%b wb=%h want 11 %h", in_ready, done,
                        wb_data, ea[15:0]);
            end
            6: if ({done, wb_data, alu_a} !== {1'b1, eb[15:0], m_rf[3]}) begin
               n_fail++;
               $display("FAIL hs_second_done: got d=%b wb=%h a=%h want 1 %h %h", done, wb_data,
                        alu_a, eb[15:0], m_rf[3]);
            end
            default: if (done !== 1'b0) begin
               n_fail++; $display("FAIL hs_done_end: got %b want 0", done);
            end
         endcase
         if (c == 3) begin
            tick();
            in_valid = 1'b0;
         end else begin
            tick();
         end
      end
      m_rf[4] = eb[15:0];
      // Load and issue requested together: only the load happens
      d6 = 16'($urandom);
      ld_en = 1'b1; ld_addr = 3'd6; ld_data = d6;
      in_valid = 1'b1; in_op = 3'd0; in_rs1 = 3'd1; in_rs2 = 3'd2; in_rd = 3'd7;
      #1;
      n_checks++;
      if (in_ready !== 1'b0) begin
         n_fail++; $display("FAIL ld_block_ready: got %b want 0", in_ready);
      end
      tick();
      ld_en = 1'b0; in_valid = 1'b0;
      m_rf[6] = d6;
      dbg_addr = 3'd6; #1;
      n_checks++;
      if ({dbg_data, in_ready} !== {d6, 1'b1}) begin
         n_fail++; $display("FAIL ld_block_load: got %h/%b want %h/1", dbg_data, in_ready, d6);
      end
      for (int c = 0; c < 3; c++) begin
         tick();
         n_checks++;
         if (done !== 1'b0) begin
            n_fail++; $display("FAIL ld_block_nodone%0d: got %b want 0", c, done);
         end
      end
   endtask

   task automatic test_reset_mid_exec();
      load(3'd1, 16'h1111);
      load(3'd2, 16'h2222);
      in_valid = 1'b1; in_op = 3'd0; in_rs1 = 3'd1; in_rs2 = 3'd2; in_rd = 3'd5;
      tick();
      in_valid = 1'b0;
      #2 reset = 1'b0;
      #1;
      dbg_addr = 3'd5; #1;
      n_checks++;
      if ({done, dbg_data, in_ready} !== {1'b0, 16'h0, 1'b1}) begin
         n_fail++;
         $display("FAIL rst_exec_during: got d=%b r5=%h rdy=%b want 0 0000 1", done, dbg_data,
                  in_ready);
      end
      tick();
      reset = 1'b1;
      clear_model();
      for (int c = 0; c < 4; c++) begin
         n_checks++;
         if ({done, dbg_data, in_ready} !== {1'b0, 16'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL rst_exec_after%0d: got d=%b r5=%h rdy=%b want 0 0000 1", c, done,
                     dbg_data, in_ready);
         end
         tick();
      end
   endtask

`ifdef ALU_ISSUE_IMM_EN
   task automatic test_imm();
      load(3'd1, 16'h0010);
      run_instr(3'd0, 3'd1, 3'($urandom), 3'd2, 1'b1, 16'h0005, "imm_add");
      dbg_addr = 3'd2; #1;
      n_checks++;
      if ({dbg_data, flag_c, flag_z} !== {16'h0015, 2'b00}) begin
         n_fail++;
         $display("FAIL imm_const: got r2=%h c=%b z=%b want 0015 0 0", dbg_data, flag_c, flag_z);
      end
      in_use_imm = 1'b0;
   endtask
`endif

   task automatic test_random();
      logic [15:0] d;
      logic        use_imm;
      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 2) == 0) begin
            case ($urandom_range(0, 3))
               0: d = 16'h0000;
               1: d = 16'hFFFF;
               2: d = 16'h8000;
               default: d = 16'($urandom);
            endcase
            load(3'($urandom), d);
         end else begin
`ifdef ALU_ISSUE_IMM_EN
            use_imm = 1'($urandom);
`else
            use_imm = 1'b0;
`endif
            run_instr(3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), use_imm,
                      16'($urandom), "random");
         end
      end
      for (int i = 0; i < 8; i++) begin
         dbg_addr = 3'(i); #1;
         n_checks++;
         if (dbg_data !== m_rf[i]) begin
            n_fail++; $display("FAIL random_rf%0d: got %h want %h", i, dbg_data, m_rf[i]);
         end
      end
   endtask

   initial begin
      clear_model();
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      test_load();
      test_add_carry();
      test_logic_alias();
      test_reset();
      test_handshake();
      test_reset_mid_exec();
`ifdef ALU_ISSUE_IMM_EN
      test_imm();
`endif
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
